// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcode/funct/ALU encodings, mux encodings and FSM states
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXECUTE,
        S_ALU_WB, S_BRANCH, S_JUMP, S_IMM_EX, S_IMM_WB, S_ILLEGAL
    } state_t;
    // ALU operation for the immediate-arithmetic opcodes; ADDI and anything else add
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : ALU_ADD;
    endfunction
endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: maps an R-type funct field to an ALU operation and a legality flag
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       funct_legal_o
);
    // Unknown functs fall back to ADD but are flagged illegal
    always_comb begin
        alu_op_o = funct_i == FN_SUB ? ALU_SUB : funct_i == FN_AND ? ALU_AND :
                   funct_i == FN_OR  ? ALU_OR  : funct_i == FN_SLT ? ALU_SLT : ALU_ADD;
        funct_legal_o = funct_i inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle MIPS control FSM; CTRL_IMM_LOGIC_EN adds ANDI/ORI/SLTI
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  branch,
    output logic                  branch_ne,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  zero_ext,
    output logic                  retire,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instr_count
);
    state_t           state_q, state_d;
    logic [5:0]       op_q, funct_q;
    logic [CNT_W-1:0] count_q;
    logic [5:0]       dec_funct;
    logic [2:0]       dec_op, alu_op;
    logic             dec_legal, imm_legal, zext_op;

    // In DECODE the live funct is checked for legality; afterwards only the registered copy drives the ALU
    assign dec_funct = state_q == S_DECODE ? funct : funct_q;

    alu_decoder u_alu_decoder (
        .funct_i       (dec_funct),
        .alu_op_o      (dec_op),
        .funct_legal_o (dec_legal)
    );

`ifdef CTRL_IMM_LOGIC_EN
    assign imm_legal = opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
    assign zext_op   = op_q inside {OP_ANDI, OP_ORI};
`else
    assign imm_legal = opcode == OP_ADDI;
    assign zext_op   = 1'b0;
`endif

    assign alu_control = ALU_CTRL_W'(alu_op);
    assign instr_count = count_q;

    // Moore output decode and next-state selection; FETCH strobes are masked while reset is held
    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = PC_ALU;
        alu_op     = ALU_ADD;
        zero_ext   = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = !reset;
                ir_write  = mem_ready && !reset;
                pc_write  = mem_ready && !reset;
                alu_src_b = SRCB_4;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                state_d   = opcode inside {OP_LW, OP_SW} ? S_MEM_ADR :
                            opcode == OP_RTYPE ? (dec_legal ? S_EXECUTE : S_ILLEGAL) :
                            opcode inside {OP_BEQ, OP_BNE} ? S_BRANCH :
                            opcode == OP_J ? S_JUMP :
                            imm_legal ? S_IMM_EX : S_ILLEGAL;
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = op_q == OP_LW ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                state_d   = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = dec_op;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                branch    = op_q == OP_BEQ;
                branch_ne = op_q == OP_BNE;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = imm_alu_op(op_q);
                zero_ext  = zext_op;
                state_d   = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
                zero_ext  = zext_op;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, latched instruction fields and the wrapping retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + CNT_W'(retire);
            if (state_q == S_DECODE) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed checks of the multi-cycle control FSM
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    logic       iord, mem_read, mem_write, ir_write, pc_write, branch, branch_ne;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, zero_ext, retire, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] instr_count;
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_cnt  = 0;

    multicycle_control_unit #(.ALU_CTRL_W(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
        .zero_ext(zero_ext), .retire(retire), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an instruction in FETCH with zero wait states and advance to DECODE
    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct = fn;
        mem_ready = 1'b1;
        #1;
        chk("fetch_mem_read", {31'd0, mem_read}, 1);
        chk("fetch_ir_write", {31'd0, ir_write}, 1);
        chk("fetch_iord", {31'd0, iord}, 0);
        tick;
    endtask

    initial begin
        reset = 1'b1;
        opcode = '0;
        funct = '0;
        mem_ready = 1'b0;
        tick;
        tick;
        chk("rst_count", {28'd0, instr_count}, 0);
        chk("rst_mem_read", {31'd0, mem_read}, 0);
        chk("rst_ir_write", {31'd0, ir_write}, 0);
        chk("rst_alu_src_b", {30'd0, alu_src_b}, 2'b01);
        reset = 1'b0;
        tick;
        // LW: five cycles, writeback in cycle 5
        fetch(6'b100011, 6'd0);
        chk("lw_dec_srcb", {30'd0, alu_src_b}, 2'b11);
        tick;
        chk("lw_adr_srca", {31'd0, alu_src_a}, 1);
        chk("lw_adr_srcb", {30'd0, alu_src_b}, 2'b10);
        tick;
        chk("lw_rd_iord", {31'd0, iord}, 1);
        chk("lw_rd_mem_read", {31'd0, mem_read}, 1);
        tick;
        chk("lw_wb_mem_to_reg", {31'd0, mem_to_reg}, 1);
        chk("lw_wb_reg_write", {31'd0, reg_write}, 1);
        chk("lw_wb_retire", {31'd0, retire}, 1);
        tick;
        chk("lw_count", {28'd0, instr_count}, 1);
        // LW aborted by asynchronous reset in MEM_RD
        fetch(6'b100011, 6'd0);
        mem_ready = 1'b0;
        tick;
        tick;
        chk("abort_in_mem_rd", {30'd0, iord, mem_read}, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_count", {28'd0, instr_count}, 0);
        chk("abort_mem_read", {31'd0, mem_read}, 0);
        chk("abort_iord", {31'd0, iord}, 0);
        chk("abort_retire", {31'd0, retire}, 0);
        tick;
        tick;
        reset = 1'b0;
        tick;
        // SW with three wait states in MEM_WR
        fetch(6'b101011, 6'd0);
        tick;
        tick;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sw_wait_write", {29'd0, mem_write, iord, retire}, 3'b110);
            tick;
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_done", {29'd0, mem_write, iord, retire}, 3'b111);
        tick;
        exp_cnt = 1;
        chk("sw_count", {28'd0, instr_count}, 32'(exp_cnt));
        chk("sw_back_fetch", {31'd0, mem_read}, 1);
        // R-type SUB; funct input changes after DECODE must not matter
        fetch(6'b000000, 6'b100010);
        tick;
        funct = 6'b100100;
        #1;
        chk("sub_alu_control", {29'd0, alu_control}, 3'b110);
        chk("sub_srca", {31'd0, alu_src_a}, 1);
        tick;
        chk("sub_wb", {29'd0, reg_dst, reg_write, retire}, 3'b111);
        tick;
        exp_cnt++;
        chk("sub_count", {28'd0, instr_count}, 32'(exp_cnt));
        // R-type with unknown funct is illegal
        fetch(6'b000000, 6'b000000);
        tick;
        chk("bad_funct_illegal", {29'd0, illegal, retire, reg_write}, 3'b100);
        tick;
        chk("bad_funct_count", {28'd0, instr_count}, 32'(exp_cnt));
        // BNE
        fetch(6'b000101, 6'd0);
        tick;
        chk("bne_flags", {30'd0, branch_ne, branch}, 2'b10);
        chk("bne_alu", {29'd0, alu_control}, 3'b110);
        chk("bne_pc_src", {30'd0, pc_src}, 2'b01);
        chk("bne_retire", {31'd0, retire}, 1);
        tick;
        exp_cnt++;
        // BEQ
        fetch(6'b000100, 6'd0);
        tick;
        chk("beq_flags", {30'd0, branch_ne, branch}, 2'b01);
        tick;
        exp_cnt++;
        // J with two fetch wait states
        opcode = 6'b000010;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("fetch_wait", {29'd0, mem_read, ir_write, pc_write}, 3'b100);
            tick;
        end
        fetch(6'b000010, 6'd0);
        tick;
        chk("j_pc_write", {31'd0, pc_write}, 1);
        chk("j_pc_src", {30'd0, pc_src}, 2'b10);
        tick;
        exp_cnt++;
        chk("j_count", {28'd0, instr_count}, 32'(exp_cnt));
        // ADDI
        fetch(6'b001000, 6'd0);
        tick;
        chk("addi_ex", {26'd0, alu_control, alu_src_b, zero_ext}, {26'd0, 3'b010, 2'b10, 1'b0});
        tick;
        chk("addi_wb", {30'd0, reg_write, retire}, 2'b11);
        tick;
        exp_cnt++;
        chk("addi_count", {28'd0, instr_count}, 32'(exp_cnt));
        // ORI depends on the optional immediate-logic build
        fetch(6'b001101, 6'd0);
        tick;
`ifdef CTRL_IMM_LOGIC_EN
        chk("ori_ex", {28'd0, alu_control, zero_ext}, {28'd0, 3'b001, 1'b1});
        tick;
        chk("ori_wb", {29'd0, zero_ext, reg_write, retire}, 3'b111);
        exp_cnt++;
`else
        chk("ori_illegal", {30'd0, illegal, retire}, 2'b10);
`endif
        tick;
        chk("ori_count", {28'd0, instr_count}, 32'(exp_cnt));
        // Counter wraps modulo 16 with a 4-bit width
        for (int i = 0; i < 16; i++) begin
            fetch(6'b000010, 6'd0);
            tick;
            tick;
        end
        chk("wrap_count", {28'd0, instr_count}, 32'(exp_cnt % 16));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
